mdu_iter: RTL and testbench

Iterative multiply/divide unit for the RV32M extension, the parametrised successor of the execute-stage ALU decode. It sits in EX next to the single-cycle ALU. It decodes opcode/funct3/funct7 itself, claims OP-type instructions with funct7 = 0000001, and runs a shift-add multiply or restoring divide over XLEN cycles. It stalls the pipeline until a one-cycle `done` pulse delivers the result.

---
 rtl/mdu_iter.sv | 190 +++++++++++++++++++
 tb/tb_mdu_iter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            is_mdu,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int cnt_w = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] int_min = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state;
    logic [cnt_w-1:0] cnt;
    logic [1:0]      op;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] addend;

    logic            start;
    logic            is_div;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            special;
    logic [XLEN-1:0] special_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi_n;
    logic [XLEN-1:0]   mul_lo_n;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   div_hi_n;
    logic [XLEN-1:0]   div_lo_n;
    logic [XLEN-1:0]   div_res;
    logic              last_iter;

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_res;
`endif

    always_comb begin
        is_mdu = (opcode == 7'b0110011) && (funct7 == 7'b0000001);
        start  = (state == IDLE) && valid_i && is_mdu && !flush;
        stall  = start || (state == MUL) || (state == DIV);
        is_div = funct3[2];

        // signedness of each operand depends on the encoding: MULHSU treats rs2 as unsigned
        sign_a = rs1_data[XLEN-1] && (is_div ? !funct3[0] : (funct3[1:0] != 2'b11));
        sign_b = rs2_data[XLEN-1] && (is_div ? !funct3[0] : !funct3[1]);
        mag_a  = sign_a ? -rs1_data : rs1_data;
        mag_b  = sign_b ? -rs2_data : rs2_data;

        special     = 1'b0;
        special_res = '0;
        if (rs2_data == '0) begin
            special     = 1'b1;
            special_res = funct3[1] ? rs1_data : '1;
        end else if (!funct3[0] && rs1_data == int_min && rs2_data == '1) begin
            special     = 1'b1;
            special_res = funct3[1] ? '0 : rs1_data;
        end

        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, addend} : '0);
        mul_hi_n = mul_sum[XLEN:1];
        mul_lo_n = {mul_sum[0], acc_lo[XLEN-1:1]};
        product  = {mul_hi_n, mul_lo_n};
        if (neg_q) product = -product;
        mul_res  = (op == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

        // remainder stays below the divisor, so a non-negative difference always fits XLEN bits
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, addend};
        if (!div_diff[XLEN]) begin
            div_hi_n = div_diff[XLEN-1:0];
            div_lo_n = {acc_lo[XLEN-2:0], 1'b1};
        end else begin
            div_hi_n = div_shift[XLEN-1:0];
            div_lo_n = {acc_lo[XLEN-2:0], 1'b0};
        end
        if (op[1]) div_res = neg_r ? -div_hi_n : div_hi_n;
        else       div_res = neg_q ? -div_lo_n : div_lo_n;

        last_iter = (cnt == cnt_w'(XLEN - 1));

`ifdef MDU_FAST_MUL_EN
        fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
        if (sign_a ^ sign_b) fast_prod = -fast_prod;
        fast_res = (funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            addend <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op    <= funct3[1:0];
                        neg_q <= sign_a ^ sign_b;
                        neg_r <= sign_a;
                        cnt   <= '0;
                        if (!is_div) begin
`ifdef MDU_FAST_MUL_EN
                            result <= fast_res;
                            done   <= 1'b1;
                            state  <= DONE;
`else
                            acc_hi <= '0;
                            acc_lo <= mag_b;
                            addend <= mag_a;
                            state  <= MUL;
`endif
                        end else if (special) begin
                            result <= special_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            acc_hi <= '0;
                            acc_lo <= mag_a;
                            addend <= mag_b;
                            state  <= DIV;
                        end
                    end
                end
                MUL: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc_hi <= mul_hi_n;
                        acc_lo <= mul_lo_n;
                        cnt    <= cnt + cnt_w'(1);
                        if (last_iter) begin
                            result <= mul_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DIV: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc_hi <= div_hi_n;
                        acc_lo <= div_lo_n;
                        cnt    <= cnt + cnt_w'(1);
                        if (last_iter) begin
                            result <= div_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed RV32M vectors plus random operations against a 64-bit arithmetic model.
module tb_mdu_iter;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        is_mdu;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MDU_FAST_MUL_EN
    localparam int mul_lat = 1;
`else
    localparam int mul_lat = 33;
`endif

    mdu_iter #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .is_mdu(is_mdu), .stall(stall), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b};       return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int   lat;
        int   cyc;
        logic stall_held;
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) lat = 1;
        else if (!f3[2]) lat = mul_lat;
        else lat = 33;
        @(negedge clk);
        valid_i = 1'b1; opcode = 7'b0110011; funct7 = 7'b0000001;
        funct3 = f3; rs1_data = a; rs2_data = b;
        #1;
        check_bit({tag, "/stall_issue"}, stall, 1'b1);
        @(negedge clk);
        valid_i = 1'b0; rs1_data = $urandom; rs2_data = $urandom;
        cyc = 1;
        stall_held = 1'b1;
        while (done !== 1'b1 && cyc < 200) begin
            if (stall !== 1'b1) stall_held = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({tag, "/latency"}, cyc, lat);
        check({tag, "/result"}, result, exp);
        check_bit({tag, "/stall_done"}, stall, 1'b0);
        check_bit({tag, "/stall_busy"}, stall_held, 1'b1);
        @(negedge clk);
        check_bit({tag, "/done_pulse"}, done, 1'b0);
    endtask

    initial begin
        logic [31:0] held;
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          seen, first, second, cyc;

        rst = 1'b1; valid_i = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
        rs1_data = '0; rs2_data = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_bit("reset/done", done, 1'b0);
        check("reset/result", result, 32'd0);
        check_bit("reset/stall", stall, 1'b0);

        run_op("mul_7_m3",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulhu_max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulh_min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhsu_m1_2", 3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF);
        run_op("div_by0",     3'd4, 32'h1234_5678, 32'd0,        32'hFFFF_FFFF);
        run_op("remu_by0",    3'd7, 32'd5,        32'd0,        32'd5);
        run_op("div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD);
        run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF);
        run_op("divu_100_7",  3'd5, 32'd100,      32'd7,        32'd14);
        run_op("remu_100_7",  3'd7, 32'd100,      32'd7,        32'd2);

        // flush mid-divide: no completion, result untouched, unit free again
        held = result;
        @(negedge clk);
        valid_i = 1'b1; opcode = 7'b0110011; funct7 = 7'b0000001;
        funct3 = 3'd5; rs1_data = 32'd1000; rs2_data = 32'd3;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_bit("flush/stall", stall, 1'b0);
        check_bit("flush/done", done, 1'b0);
        check("flush/result", result, held);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("flush/no_done", seen, 0);
        run_op("after_flush", 3'd5, 32'd1000, 32'd3, 32'd333);

        // reset mid-divide clears result
        @(negedge clk);
        valid_i = 1'b1; funct3 = 3'd5; rs1_data = 32'd1000; rs2_data = 32'd3;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_bit("rst/stall", stall, 1'b0);
        check_bit("rst/done", done, 1'b0);
        check("rst/result", result, 32'd0);
        run_op("after_rst", 3'd7, 32'd1000, 32'd7, 32'd6);

        // non-MDU instruction is ignored
        @(negedge clk);
        valid_i = 1'b1; opcode = 7'b0110011; funct7 = 7'b0000000; funct3 = 3'd0;
        rs1_data = 32'd3; rs2_data = 32'd4;
        #1;
        check_bit("add/is_mdu", is_mdu, 1'b0);
        check_bit("add/stall", stall, 1'b0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        valid_i = 1'b0;
        check("add/no_done", seen, 0);
        held = result;
        check("add/result", result, 32'd6);

        // back-to-back MULs with valid held high
        @(negedge clk);
        valid_i = 1'b1; opcode = 7'b0110011; funct7 = 7'b0000001; funct3 = 3'd0;
        rs1_data = 32'd7; rs2_data = 32'hFFFF_FFFD;
        first = -1; second = -1; cyc = 0;
        while (second < 0 && cyc < 200) begin
            if (done === 1'b1) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
            if (second < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        valid_i = 1'b0;
        check("b2b/first_done", first, mul_lat);
        check("b2b/spacing", second - first, mul_lat + 1);
        check("b2b/result", result, 32'hFFFF_FFEB);
        @(negedge clk);

        // random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rand%0d_f%0d", i, f3), f3, a, b, ref_mdu(f3, a, b));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
